// File: rtl/ex_muldiv_if.sv
// Handshake/result bundle between the EX-stage control and the multi-cycle HI/LO unit.
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic             annul_i;
    logic             stallreq_o;
    logic             done_o;
    logic             whilo_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
        input  stallreq_o, done_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, hi_i, lo_i, annul_i,
        output stallreq_o, done_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MADD/MSUB/DIV unit for the EX stage; stalls the pipe, then writes HI/LO once.
// Divider support is built only when MULDIV_DIV_EN is defined; otherwise ops 7-8 act as NOP.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 6
) (
    input logic         clk,
    input logic         rst,
    ex_muldiv_if.slave  bus_io
);
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpMadd  = 4'd3;
    localparam logic [3:0] OpMaddu = 4'd4;
    localparam logic [3:0] OpMsub  = 4'd5;
    localparam logic [3:0] OpMsubu = 4'd6;
    localparam logic [3:0] OpDiv   = 4'd7;
    localparam logic [3:0] OpDivu  = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
`ifdef MULDIV_DIV_EN
        , StDiv = 2'd3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    res_q, res_d;

    logic          is_mul_op, is_div_op, accept, stall;
    logic          mul_signed;
    logic [W2-1:0] ext_a, ext_b, prod;

    always_comb begin
        is_mul_op = (bus_io.op_i >= OpMult) && (bus_io.op_i <= OpMsubu);
`ifdef MULDIV_DIV_EN
        is_div_op = (bus_io.op_i == OpDiv) || (bus_io.op_i == OpDivu);
`else
        is_div_op = 1'b0;
`endif
        accept = bus_io.start_i && !bus_io.annul_i && (is_mul_op || is_div_op);
    end

    // Sign-extend to 2*WIDTH so a truncated product is correct for both signednesses.
    always_comb begin
        mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
        ext_a = mul_signed ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
        ext_b = mul_signed ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
        prod  = ext_a * ext_b;
    end

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             div_signed, a_neg, b_neg, ai_neg;
    logic [WIDTH-1:0] dvs_mag, dvd_mag_in;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n, rem_fix, quo_fix;

    always_comb begin
        div_signed = (op_q == OpDiv);
        a_neg      = div_signed && opa_q[WIDTH-1];
        b_neg      = div_signed && opb_q[WIDTH-1];
        dvs_mag    = b_neg ? (~opb_q + 1'b1) : opb_q;
        ai_neg     = (bus_io.op_i == OpDiv) && bus_io.opa_i[WIDTH-1];
        dvd_mag_in = ai_neg ? (~bus_io.opa_i + 1'b1) : bus_io.opa_i;

        // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_mag};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo_fix = (a_neg ^ b_neg) ? (~quo_n + 1'b1) : quo_n;
        rem_fix = a_neg ? (~rem_n + 1'b1) : rem_n;
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        stall   = 1'b0;
`ifdef MULDIV_DIV_EN
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall = 1'b1;
                    op_d  = bus_io.op_i;
                    opa_d = bus_io.opa_i;
                    opb_d = bus_io.opb_i;
                    acc_d = {bus_io.hi_i, bus_io.lo_i};
                    if (is_mul_op) begin
                        state_d = StMul;
                    end
`ifdef MULDIV_DIV_EN
                    else if (bus_io.opb_i == '0) begin
                        res_d   = {bus_io.opa_i, {WIDTH{1'b1}}};
                        state_d = StDone;
                    end else begin
                        rem_d   = '0;
                        quo_d   = dvd_mag_in;
                        cnt_d   = '0;
                        state_d = StDiv;
                    end
`endif
                end
            end
            StMul: begin
                if (bus_io.annul_i) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    if ((op_q == OpMadd) || (op_q == OpMaddu)) begin
                        res_d = acc_q + prod;
                    end else if ((op_q == OpMsub) || (op_q == OpMsubu)) begin
                        res_d = acc_q - prod;
                    end else begin
                        res_d = prod;
                    end
                    state_d = StDone;
                end
            end
`ifdef MULDIV_DIV_EN
            StDiv: begin
                if (bus_io.annul_i) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        res_d   = {rem_fix, quo_fix};
                        state_d = StDone;
                    end
                end
            end
`endif
            StDone: begin
                // start_i here still belongs to the completing instruction.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    logic in_done;
    assign in_done = (state_q == StDone);

    // Reset gating keeps the combinational stall low while rst is held.
    assign bus_io.stallreq_o = stall && !rst;
    assign bus_io.whilo_o    = in_done && !bus_io.annul_i;
    assign bus_io.done_o     = in_done && !bus_io.annul_i;
    assign bus_io.hi_o       = in_done ? res_q[W2-1:WIDTH] : '0;
    assign bus_io.lo_o       = in_done ? res_q[WIDTH-1:0] : '0;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv; DIV vectors run when MULDIV_DIV_EN is defined.
module tb_ex_muldiv;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(WIDTH)) bus ();

    ex_muldiv #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        bus.start_i = s;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        bus.hi_i    = h;
        bus.lo_i    = l;
    endtask

    // {stall, whilo, done}
    function automatic logic [2:0] flags();
        return {bus.stallreq_o, bus.whilo_o, bus.done_o};
    endfunction

    task automatic run_mul(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                           input logic [63:0] exp);
        drive(1'b1, op, a, b, h, l);
        #2;
        chk({tag, "_c0"}, {61'd0, flags()}, 64'b100);
        cyc();
        #2;
        chk({tag, "_c1"}, {61'd0, flags()}, 64'b100);
        cyc();
        #2;
        chk({tag, "_c2_flags"}, {61'd0, flags()}, 64'b011);
        chk({tag, "_c2_res"}, {bus.hi_o, bus.lo_o}, exp);
        cyc();
    endtask

`ifdef MULDIV_DIV_EN
    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        drive(1'b1, op, a, b, 32'h0, 32'h0);
        #2;
        chk({tag, "_c0"}, {61'd0, flags()}, 64'b100);
        for (int i = 1; i <= WIDTH; i++) begin
            cyc();
            #2;
            chk({tag, "_stall"}, {61'd0, flags()}, 64'b100);
        end
        cyc();
        #2;
        chk({tag, "_done_flags"}, {61'd0, flags()}, 64'b011);
        chk({tag, "_done_res"}, {bus.hi_o, bus.lo_o}, exp);
        cyc();
    endtask
`endif

    initial begin
        bus.annul_i = 1'b0;
        drive(1'b1, 4'd1, 32'd3, 32'd4, 32'd0, 32'd0);
        rst = 1'b1;
        #3;
        chk("reset_flags", {61'd0, flags()}, 64'b000);
        chk("reset_res", {bus.hi_o, bus.lo_o}, 64'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        #2;
        chk("idle_flags", {61'd0, flags()}, 64'b000);
        cyc();

        // Back-to-back multiply-class ops, no bubble between them.
        run_mul("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mul("maddu", 4'd4, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000);
        run_mul("msub", 4'd5, 32'd2, 32'd3, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFA);
        run_mul("madd", 4'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd10, 64'h0000_0000_0000_0008);
        run_mul("msubu", 4'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFE_0000_0002);

        // NOP encodings never stall or write.
        drive(1'b1, 4'd0, 32'd7, 32'd7, 32'd0, 32'd0);
        #2;
        chk("nop0", {61'd0, flags()}, 64'b000);
        cyc();
        drive(1'b1, 4'd12, 32'd7, 32'd7, 32'd0, 32'd0);
        #2;
        chk("nop12", {61'd0, flags()}, 64'b000);
        cyc();

        // Annul on the start cycle: nothing accepted.
        bus.annul_i = 1'b1;
        drive(1'b1, 4'd1, 32'd7, 32'd7, 32'd0, 32'd0);
        #2;
        chk("annul_idle", {61'd0, flags()}, 64'b000);
        cyc();
        bus.annul_i = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        chk("annul_idle_next", {61'd0, flags()}, 64'b000);
        cyc();

        // Annul in MUL: stall drops, no write follows.
        drive(1'b1, 4'd1, 32'd7, 32'd7, 32'd0, 32'd0);
        cyc();
        bus.annul_i = 1'b1;
        #2;
        chk("annul_mul", {61'd0, flags()}, 64'b000);
        cyc();
        bus.annul_i = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2;
        chk("annul_mul_next", {61'd0, flags()}, 64'b000);
        cyc();

`ifdef MULDIV_DIV_EN
        run_div("div_neg7_2", 4'd7, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_div("div_ovf", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_div("divu_100_7", 4'd8, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        // Divide by zero completes in C1.
        drive(1'b1, 4'd8, 32'd100, 32'd0, 32'd0, 32'd0);
        #2;
        chk("divz_c0", {61'd0, flags()}, 64'b100);
        cyc();
        #2;
        chk("divz_c1_flags", {61'd0, flags()}, 64'b011);
        chk("divz_c1_res", {bus.hi_o, bus.lo_o}, 64'h0000_0064_FFFF_FFFF);
        cyc();

        // Annul at C10 of a DIV, then a MULT from C11 completes in C13.
        drive(1'b1, 4'd7, 32'd1000, 32'd3, 32'd0, 32'd0);
        for (int i = 1; i <= 10; i++) cyc();
        bus.annul_i = 1'b1;
        #2;
        chk("div_annul_c10", {61'd0, flags()}, 64'b000);
        cyc();
        bus.annul_i = 1'b0;
        run_mul("mult_after_annul", 4'd1, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42);
`else
        // Without the divider, DIV/DIVU are NOPs.
        drive(1'b1, 4'd7, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        #2;
        chk("div_disabled", {61'd0, flags()}, 64'b000);
        cyc();
        drive(1'b1, 4'd8, 32'd100, 32'd0, 32'd0, 32'd0);
        #2;
        chk("divu_disabled", {61'd0, flags()}, 64'b000);
        cyc();
        #2;
        chk("divu_disabled_next", {61'd0, flags()}, 64'b000);
        cyc();
`endif

        // Asynchronous reset mid-MUL, between clock edges.
        drive(1'b1, 4'd1, 32'd9, 32'd9, 32'd0, 32'd0);
        cyc();
        #2;
        chk("pre_rst_stall", {61'd0, flags()}, 64'b100);
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", {61'd0, flags()}, 64'b000);
        chk("rst_mid_res", {bus.hi_o, bus.lo_o}, 64'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc();
        rst = 1'b0;
        #2;
        chk("post_rst_idle", {61'd0, flags()}, 64'b000);
        cyc();
        #2;
        chk("post_rst_no_done", {61'd0, flags()}, 64'b000);
        run_mul("multu_after_rst", 4'd2, 32'd3, 32'd4, 32'd0, 32'd0, 64'd12);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
